// File: rtl/multiplicator_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digit
// selects and the iteration-count helper.
package multiplicator_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_e;

   typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_sel_e;

   function automatic int booth_iter(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth digit decode: turns a multiplier triplet into a select and
// the matching signed partial product of the extended multiplicand.
module booth_pp_sel
   import multiplicator_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]       triplet,
   input  logic [WIDTH+1:0] mcand,
   output booth_sel_e       sel,
   output logic [WIDTH+2:0] pp
);

   logic [WIDTH+2:0] a1, a2;

   // mcand is already sign/zero extended by the caller, so one more sign bit
   // gives A, and a left shift gives 2A without overflow.
   assign a1 = {mcand[WIDTH+1], mcand};
   assign a2 = {mcand, 1'b0};

   always_comb begin
      sel = ZERO;
      case (triplet)
         3'b001, 3'b010: sel = POS1;
         3'b011:         sel = POS2;
         3'b100:         sel = NEG2;
         3'b101, 3'b110: sel = NEG1;
         default:        sel = ZERO;
      endcase
   end

   always_comb begin
      pp = '0;
      case (sel)
         POS1:    pp = a1;
         POS2:    pp = a2;
         NEG1:    pp = -a1;
         NEG2:    pp = -a2;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_multiplicator.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per cycle, with
// per-operation signed/unsigned mode and valid/ready on both sides.
module booth_multiplicator
   import multiplicator_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product
);

   localparam int ITER = booth_iter(WIDTH);
   localparam int EW   = WIDTH + 2;
   localparam int PW   = WIDTH + 3;
   localparam int AW   = 2 * WIDTH + 4;
   localparam int CW   = $clog2(ITER);

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $fatal(1, "booth_multiplicator: WIDTH must be even and >= 4");
      end
   endgenerate

   mult_state_e      state, state_nxt;
   logic [EW-1:0]    a_ext;
   logic [EW:0]      b_sh;
   logic [AW-1:0]    acc, acc_nxt, pp_ext;
   logic [CW-1:0]    cnt;
   logic             last;
   booth_sel_e       sel;
   logic [PW-1:0]    pp;

   booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
      .triplet (b_sh[2:0]),
      .mcand   (a_ext),
      .sel     (sel),
      .pp      (pp)
   );

   assign last    = (cnt == CW'(ITER - 1));
   assign pp_ext  = {{(AW - PW){pp[PW-1]}}, pp};
   // cnt counts digits, so the partial product weight is 4^cnt.
   assign acc_nxt = (sel == ZERO) ? acc : acc + (pp_ext << {cnt, 1'b0});

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = CALC;
         CALC:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // The mode only matters for the extension, so it is folded into the
   // operand registers at accept and never stored separately.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_ext       <= '0;
         b_sh        <= '0;
         acc         <= '0;
         cnt         <= '0;
         out_product <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_ext <= in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
               b_sh  <= in_signed ? {{2{in_b[WIDTH-1]}}, in_b, 1'b0}
                                  : {2'b00, in_b, 1'b0};
               acc   <= '0;
               cnt   <= '0;
            end
            CALC: begin
               acc  <= acc_nxt;
               cnt  <= cnt + 1'b1;
               b_sh <= b_sh >> 2;
               if (last) out_product <= acc_nxt[2*WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/booth_multiplicator.md
Name: booth_multiplicator

Overview:
Parametrised iterative radix-4 Booth multiplier. It is the next generation of the fixed 16-bit fast multiplier.
- Adds a per-operation signed/unsigned mode.
- Adds valid/ready handshakes on input and output, with output back-pressure.
- Adds a configurable operand width.
- Sits between an operand producer and a result consumer. It retires 2 multiplier bits per cycle.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration-time check, fatal otherwise)
ITER, WIDTH/2+1, derived localparam; number of Booth iterations (9 for WIDTH=16); not overridable

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_signed  input  1  1 = both operands two's complement, 0 = both unsigned; sampled with operands
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_product  output  2*WIDTH  product, signed or unsigned per the sampled mode

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_product=0, accumulator=0.
  - Reset wins over every other input on the same edge.
  - Reset mid-CALC or mid-DONE discards the operation; no result is produced.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: on an edge with state=IDLE and in_valid=1:
  - Latch in_a, in_b and in_signed.
  - Extend both operands to WIDTH+2 bits: sign-extend if in_signed=1, zero-extend otherwise.
  - Clear the accumulator, set the iteration counter to 0, go to CALC.
- CALC, each edge:
  - Examine Booth triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Select 0, +A, +2A, -A or -2A.
  - Add it to the accumulator at weight 4^i. Arithmetic is 2*WIDTH+4 bits wide, two's complement.
  - Increment the counter.
  - After the edge on which counter = ITER-1 is processed, go to DONE. On that same edge, load out_product with the low 2*WIDTH bits of the accumulator.
- Latency: out_valid rises exactly ITER edges after the accept edge (9 for WIDTH=16).
- DONE: out_valid=1, and out_product is held stable until the handshake.
  - On an edge with out_ready=1, go to IDLE.
  - out_valid deasserts on that edge. out_product keeps its last value (not cleared).
- Back-pressure: DONE is held indefinitely while out_ready=0. No operand is accepted meanwhile.
- Throughput: one operation per ITER+2 cycles at best (accept, ITER CALC edges, release). Input and output phases do not overlap.
- Inputs ignored: in_valid, in_a, in_b and in_signed are ignored outside IDLE. out_ready is ignored outside DONE.
- No overflow is possible: 2*WIDTH bits always hold the full product in both modes.
- Unsigned mode is exact for operands with MSB=1, via the zero-extended top Booth digit.
- Signed corner: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), which is representable.
- out_product changes only on the CALC->DONE edge or on reset.

Decomposition:
- Package multiplicator_pkg:
  - state enum mult_state_e {IDLE, CALC, DONE}.
  - Booth select enum booth_sel_e {ZERO, POS1, POS2, NEG1, NEG2}.
  - Function booth_iter(width), returning width/2+1.
- One sub-module, booth_pp_sel: combinational decode of a 3-bit triplet into a booth_sel_e. It also produces the WIDTH+3-bit signed partial product from the extended multiplicand.
- Top module: FSM, counter, operand/accumulator registers and handshake logic.

Test Plan:
All values are for WIDTH=16.
- Unsigned small: a=3, b=5, signed=0 -> out_valid 9 edges after accept, product=0x0000000F; in_ready low throughout CALC and DONE.
- Signed negative: a=0xFFFD (-3), b=5, signed=1 -> 0xFFFFFFF1. Same operands with signed=0 -> 0x0004FFF1.
- Unsigned max: a=b=0xFFFF, signed=0 -> 0xFFFE0001. Signed min: a=b=0x8000, signed=1 -> 0x40000000.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid, then pulse 1 -> product stable throughout; IDLE one edge after the handshake; in_valid pulses during the stall are not accepted.
- Reset mid-CALC: assert reset on the 4th CALC edge -> next cycle in_ready=1, out_valid=0, out_product=0. A new op 7*6 unsigned then yields 0x0000002A with full latency.
- Random regression, all four mode/sign combinations, back-to-back valid with random out_ready -> scoreboard matches the reference model. Also repeat with WIDTH=8 and WIDTH=32.
